// File: rtl/bin2bcd_8bit.sv
// bin2bcd_8bit: sequential shift-and-add-3 binary to packed BCD converter with start/busy/done handshake
module bin2bcd_8bit #(
  parameter int bitwidth = 8,
  parameter int digits = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [bitwidth-1:0]   Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*digits-1:0]   Bcd
);
  localparam int W = 4 * digits;
  localparam int CW = $clog2(bitwidth + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q;
  logic [W+bitwidth-1:0] sr_q, sr_d;
  logic [W-1:0]        adj;
  logic [CW-1:0]       cnt_q;
  logic [W-1:0]        bcd_q;
  logic                done_q;
  genvar d;
  generate
    for (d = 0; d < digits; d++) begin : g_add3
      assign adj[4*d+:4] = sr_q[bitwidth+4*d+:4] >= 4'd5 ? sr_q[bitwidth+4*d+:4] + 4'd3 : sr_q[bitwidth+4*d+:4];
    end
  endgenerate
  // one double-dabble step: corrected scratch digits then shift the whole register left
  always_comb sr_d = {adj, sr_q[bitwidth-1:0]} << 1;
  // control FSM; Bcd only loads on the final shift so it never shows partial values
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (Start) begin
          sr_q    <= {{W{1'b0}}, Bin};
          cnt_q   <= CW'(bitwidth);
          state_q <= SHIFT;
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            bcd_q   <= sr_d[W+bitwidth-1:bitwidth];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Busy = state_q != IDLE;
  assign Done = done_q;
  assign Bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_8bit.sv
// tb_bin2bcd_8bit: scoreboard bench for the double-dabble converter
module tb_bin2bcd_8bit;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Bin = '0;
  logic        Busy, Done;
  logic [11:0] Bcd;
  int          vectors = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] prev_bcd = '0;
  logic        rst_last = 1'b1;

  bin2bcd_8bit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Bcd(Bcd)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rst_last <= Reset;

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor: pops an expected result on every Done and checks that Bcd holds otherwise
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Bcd %0h, expected no Done", Bcd);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("bcd", Bcd, e);
        check("digits_le9", int'(Bcd[3:0] <= 4'd9 && Bcd[7:4] <= 4'd9 && Bcd[11:8] <= 4'd2), 1);
      end
    end
    if (!Done && !rst_last && Bcd != prev_bcd) begin
      errors++;
      $display("FAIL bcd_hold: got %0h, expected %0h", Bcd, prev_bcd);
    end
    prev_bcd = Bcd;
  end

  task automatic wait_idle();
    int k = 0;
    while (Busy && k < 30) begin
      @(negedge Clk);
      k++;
    end
    if (Busy) begin
      errors++;
      $display("FAIL idle_timeout: got Busy 1, expected 0");
    end
  endtask

  // mode 0: plain; mode 1: re-pulse Start with Bin=7 mid-shift
  task automatic convert(input int b, input int mode);
    int cyc, busy_n;
    wait_idle();
    Bin = 8'(b);
    Start = 1'b1;
    exp_q.push_back(ref_bcd(b));
    @(negedge Clk);
    Start = 1'b0;
    Bin = 8'($urandom);
    cyc = 1;
    busy_n = 0;
    while (!Done && cyc < 20) begin
      if (Busy) busy_n++;
      if (mode == 1 && cyc == 3) begin
        Start = 1'b1;
        Bin = 8'd7;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    Start = 1'b0;
    if (Busy) busy_n++;
    check("done_latency", cyc, 9);
    check("busy_cycles", busy_n, 9);
    @(negedge Clk);
    check("done_one_cycle", int'(Done), 0);
    check("busy_low_after", int'(Busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_bcd", Bcd, 0);
    Reset = 1'b0;
    @(negedge Clk);
    convert(0, 0);
    convert(255, 0);
    convert(225, 0);
    convert(99, 0);
    convert(100, 0);
    for (int v = 0; v < 256; v++) convert(v, 0);
    convert(200, 1);
    wait_idle();
    Bin = 8'd123;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", int'(Busy), 0);
    check("abort_done", int'(Done), 0);
    check("abort_bcd", Bcd, 0);
    repeat (12) @(negedge Clk);
    check("abort_bcd_hold", Bcd, 0);
    convert(42, 0);
    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    repeat (3) @(negedge Clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
